// File: rtl/data_ram_param.sv
// Single-port data memory for the load/store stage: byte-enable writes, req/ready
// handshake, 1- or 2-cycle read pipeline, out-of-range detection, post-reset clear.
module data_ram_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    writeEnable,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   dataC,
  output logic                    ready,
  output logic                    readValid,
  output logic [DATA_WIDTH-1:0]   dataRAMOutput,
  output logic                    addrError
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]       LAST    = IW'(DEPTH - 1);

  typedef enum logic {sClear, sRun} stateT;

  stateT           stateQ, stateNext;
  logic [IW-1:0]   cnt;
  logic            readyQ, clearWe;
  logic            wrAcc, rdAcc, inRange;
  logic [IW-1:0]   idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State register; ready is registered so it is low for the whole reset window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= (CLEAR_ON_RESET != 0) ? sClear : sRun;
      cnt    <= '0;
      readyQ <= 1'b0;
    end else begin
      stateQ <= stateNext;
      readyQ <= (stateNext == sRun);
      if (clearWe) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    stateNext = stateQ;
    if (stateQ == sClear && cnt == LAST) stateNext = sRun;
  end

  always_comb begin
    clearWe = (stateQ == sClear);
  end

  assign ready   = readyQ;
  assign wrAcc   = req && readyQ && writeEnable;
  assign rdAcc   = req && readyQ && !writeEnable;
  assign inRange = ({1'b0, address} < DEPTH_X);
  assign idx     = address[IW-1:0];

  always_ff @(posedge clock) begin
    if (clearWe) mem[cnt] <= '0;
    else if (wrAcc && inRange)
      for (int b = 0; b < NB; b++)
        if (byteEnable[b]) mem[idx][8*b +: 8] <= dataC[8*b +: 8];
  end

  // Stage 1 samples the array; further stages only advance on a valid slot,
  // so the output register holds its last read value between pulses.
  logic [READ_LATENCY:1]  vldPipe, errPipe;
  logic [DATA_WIDTH-1:0]  dataPipe [1:READ_LATENCY];
  logic                   wrErrQ;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vldPipe <= '0;
      errPipe <= '0;
      wrErrQ  <= 1'b0;
      for (int k = 1; k <= READ_LATENCY; k++) dataPipe[k] <= '0;
    end else begin
      vldPipe[1] <= rdAcc;
      errPipe[1] <= rdAcc && !inRange;
      wrErrQ     <= wrAcc && !inRange;
      if (rdAcc) dataPipe[1] <= inRange ? mem[idx] : '0;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vldPipe[k] <= vldPipe[k-1];
        errPipe[k] <= errPipe[k-1];
        if (vldPipe[k-1]) dataPipe[k] <= dataPipe[k-1];
      end
    end
  end

  assign readValid     = vldPipe[READ_LATENCY];
  assign dataRAMOutput = dataPipe[READ_LATENCY];
  assign addrError     = wrErrQ | errPipe[READ_LATENCY];
endmodule

// File: tb/tb_data_ram_param.sv
// Drives identical traffic into a latency-1 and a latency-2 instance and checks both
// against a cycle-indexed event log of accepted requests.
module tb_data_ram_param;
  localparam int DW = 32, AW = 5, DEPTH = 16, NB = 4, MAXC = 4096;

  logic clock = 1'b0, reset = 1'b1, req = 1'b0, writeEnable = 1'b0;
  logic [NB-1:0] byteEnable = '0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] dataC = '0;
  logic ready1, rv1, err1, ready2, rv2, err2;
  logic [DW-1:0] out1, out2;

  always #5 clock = ~clock;

  data_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1),
                   .CLEAR_ON_RESET(1)) dut1 (
    .clock(clock), .reset(reset), .req(req), .writeEnable(writeEnable),
    .byteEnable(byteEnable), .address(address), .dataC(dataC), .ready(ready1),
    .readValid(rv1), .dataRAMOutput(out1), .addrError(err1));

  data_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2),
                   .CLEAR_ON_RESET(1)) dut2 (
    .clock(clock), .reset(reset), .req(req), .writeEnable(writeEnable),
    .byteEnable(byteEnable), .address(address), .dataC(dataC), .ready(ready2),
    .readValid(rv2), .dataRAMOutput(out2), .addrError(err2));

  // Reference: memory image plus a log of what was accepted at each clock edge.
  logic [DW-1:0] mMem [DEPTH];
  bit            rdAt [MAXC];
  bit            rdErr [MAXC];
  bit            wErrAt [MAXC];
  logic [DW-1:0] rdData [MAXC];
  int cycle = 0, epoch = 0, sinceRel = -1;
  logic [DW-1:0] hold1 = '0, hold2 = '0;
  int passed = 0, total = 0, failed = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  task automatic checkOutputs();
    bit v1, v2;
    bit we;
    int s2;
    s2 = cycle - 1;
    we = (cycle >= epoch) && wErrAt[cycle];
    v1 = (cycle >= epoch) && rdAt[cycle];
    v2 = (s2 >= epoch) && (s2 >= 0) && rdAt[s2];
    if (v1) hold1 = rdData[cycle];
    if (v2) hold2 = rdData[s2];
    check("ready1", ready1, sinceRel >= DEPTH);
    check("ready2", ready2, sinceRel >= DEPTH);
    check("readValid1", rv1, v1);
    check("readValid2", rv2, v2);
    check("data1", out1, hold1);
    check("data2", out2, hold2);
    check("addrError1", err1, we | (v1 && rdErr[cycle]));
    check("addrError2", err2, we | (v2 && rdErr[s2]));
  endtask

  task automatic step(input bit r, input bit w, input logic [NB-1:0] be,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    int ai;
    req = r; writeEnable = w; byteEnable = be; address = a; dataC = d;
    acc = r && (sinceRel >= DEPTH);
    ai  = int'(a);
    @(posedge clock);
    cycle++;
    if (sinceRel >= 0) sinceRel++;
    if (acc && w) begin
      if (ai < DEPTH) begin
        for (int b = 0; b < NB; b++) if (be[b]) mMem[ai][8*b +: 8] = d[8*b +: 8];
      end else wErrAt[cycle] = 1'b1;
    end
    if (acc && !w) begin
      rdAt[cycle]   = 1'b1;
      rdErr[cycle]  = (ai >= DEPTH);
      rdData[cycle] = (ai < DEPTH) ? mMem[ai] : '0;
    end
    @(negedge clock);
    checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Asserted at a negedge; outputs must drop without waiting for a clock edge.
  task automatic doReset(input int n);
    reset = 1'b1;
    req = 1'b0;
    #1;
    epoch = cycle + 1;
    sinceRel = -1;
    hold1 = '0;
    hold2 = '0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    checkOutputs();
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'hF, AW'(i), 32'hFFFF_FFFF);
    @(negedge clock);
    reset = 1'b0;
    sinceRel = 0;
  endtask

  initial begin
    @(negedge clock);
    doReset(2);
    // Requests during the clear window must be ignored.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 4'hF, AW'(i), 32'h5A5A_5A5A);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, AW'(i), '0);
    idle(2);

    step(1'b1, 1'b1, 4'hF, 5'd5, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, '0, 5'd5, '0);
    idle(2);
    check("t2_const", out2, 32'hDEAD_BEEF);

    step(1'b1, 1'b1, 4'b0101, 5'd5, 32'h1122_3344);
    step(1'b1, 1'b0, '0, 5'd5, '0);
    idle(2);
    check("t3_const", out2, 32'hDE22_BE44);

    step(1'b1, 1'b1, 4'hF, 5'd16, 32'hCAFE_F00D);
    step(1'b1, 1'b0, '0, 5'd16, '0);
    step(1'b1, 1'b0, '0, 5'd0, '0);
    idle(2);

    step(1'b1, 1'b1, 4'hF, 5'd1, 32'hA);
    step(1'b1, 1'b1, 4'hF, 5'd2, 32'hB);
    step(1'b1, 1'b1, 4'hF, 5'd3, 32'hC);
    step(1'b1, 1'b0, '0, 5'd1, '0);
    step(1'b1, 1'b0, '0, 5'd2, '0);
    step(1'b1, 1'b0, '0, 5'd3, '0);
    idle(3);
    check("t5_const", out2, 32'hC);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0, NB'($urandom),
           AW'($urandom_range(0, 20)), $urandom);
    idle(2);

    // Reset with two reads in flight, then again partway through the clear.
    step(1'b1, 1'b0, '0, 5'd1, '0);
    step(1'b1, 1'b0, '0, 5'd2, '0);
    doReset(1);
    idle(7);
    doReset(1);
    idle(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, AW'(i), '0);
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, NB'($urandom),
           AW'($urandom_range(0, 31)), $urandom);
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
